// File: rtl/rv_pipe_pkg.sv
// rv_pipe_pkg: shared helpers for the rvpipe elastic buffer family.
//   ptr_w   : pointer width for a DEPTH-entry buffer (at least 1 bit).
//   ptr_inc : pointer increment that wraps from depth-1 back to 0, so
//             non-power-of-two depths work without relying on overflow.
package rv_pipe_pkg;

  function automatic int ptr_w(input int depth);
    int w;
    w = $clog2(depth);
    if (w < 32'sd1) begin
      return 32'sd1;
    end else begin
      return w;
    end
  endfunction

  function automatic int ptr_inc(input int ptr, input int depth);
    if (ptr >= depth - 32'sd1) begin
      return 32'sd0;
    end else begin
      return ptr + 32'sd1;
    end
  endfunction

endpackage

// File: rtl/rvpipe_elastic_chk.sv
// rvpipe_elastic_chk: simulation-only properties of the elastic buffer.
// Ports (all inputs): clk, rst_l, flush, out_valid, out_ready, out_data, count.
//   - occupancy never exceeds DEPTH
//   - a stalled head (valid, not consumed, not flushed) keeps its payload
module rvpipe_elastic_chk #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNTW  = $clog2(DEPTH + 1)
) (
  input logic             clk,
  input logic             rst_l,
  input logic             flush,
  input logic             out_valid,
  input logic             out_ready,
  input logic [WIDTH-1:0] out_data,
  input logic [CNTW-1:0]  count
);

  a_count_max : assert property (@(posedge clk) disable iff (rst_l)
    count <= CNTW'(DEPTH));

  a_head_stable : assert property (@(posedge clk) disable iff (rst_l)
    (out_valid && !out_ready && !flush) |=> $stable(out_data));

endmodule

// File: rtl/rvpipe_elastic_ptr.sv
// rvpipe_ptr: wrap-around pointer register for the elastic buffer.
// Ports:
//   clk   in   clock, rising edge
//   rst_l in   asynchronous reset, active-high
//   inc   in   advance pointer by one (wraps DEPTH-1 -> 0)
//   clr   in   synchronous clear to 0, wins over inc
//   ptr   out  current pointer value (registered)
module rvpipe_ptr
  import rv_pipe_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_l,
  input  logic          inc,
  input  logic          clr,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] ptr_r;

  // Pointer state: clear has priority, increment wraps explicitly.
  always_ff @(posedge clk or posedge rst_l) begin
    if (rst_l) begin
      ptr_r <= '0;
    end else if (clr) begin
      ptr_r <= '0;
    end else if (inc) begin
      ptr_r <= PW'(ptr_inc(int'(ptr_r), DEPTH));
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign ptr = ptr_r;

endmodule

// File: rtl/rvpipe_elastic.sv
// rvpipe_elastic: DEPTH-entry registered elastic buffer with valid/ready on
// both sides, global stall enable, synchronous flush and occupancy count.
// in_ready has no path from out_ready, so a full buffer cannot push and pop
// in the same cycle.
// Ports:
//   clk       in   clock, rising edge
//   rst_l     in   asynchronous reset, active-high
//   en        in   global stage enable (0 = full stall)
//   flush     in   synchronous flush, discards all entries, ignores en
//   in_valid  in   upstream has data
//   in_ready  out  buffer accepts data this cycle
//   in_data   in   upstream payload [WIDTH]
//   out_valid out  head entry valid
//   out_ready in   downstream consumes head
//   out_data  out  head payload [WIDTH], straight from storage flops
//   count     out  entries held, 0..DEPTH [CNTW]
module rvpipe_elastic
  import rv_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNTW-1:0]  count
);

  localparam int PW = ptr_w(DEPTH);

  if (DEPTH < 1) begin : g_bad_depth
    $error("rvpipe_elastic: DEPTH must be >= 1");
  end

  logic [CNTW-1:0]  count_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_s;
  logic [PW-1:0]    rd_ptr_s;
  logic             push_s;
  logic             pop_s;
  logic             full_s;
  logic [DEPTH-1:0] we_s;

  assign full_s    = (count_r >= CNTW'(DEPTH));
  // Reset term keeps in_ready low while rst_l is held, even though count is 0.
  assign in_ready  = en & ~flush & ~full_s & ~rst_l;
  assign out_valid = (count_r != CNTW'(0));
  assign out_data  = mem_r[rd_ptr_s];
  assign count     = count_r;

  assign push_s = en & in_valid & in_ready;
  assign pop_s  = en & out_valid & out_ready;

  rvpipe_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .rst_l (rst_l),
    .inc   (push_s),
    .clr   (flush),
    .ptr   (wr_ptr_s)
  );

  rvpipe_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .rst_l (rst_l),
    .inc   (pop_s),
    .clr   (flush),
    .ptr   (rd_ptr_s)
  );

  // Per-entry write enable decoded from the write pointer.
  always_comb begin
    we_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      we_s[i] = push_s & (wr_ptr_s == PW'(i));
    end
  end

  // Storage flops; flush leaves contents alone since they are unreachable.
  always_ff @(posedge clk or posedge rst_l) begin
    if (rst_l) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (we_s[i]) begin
          mem_r[i] <= in_data;
        end
      end
    end
  end

  // Occupancy: flush wins, simultaneous push and pop cancel out.
  always_ff @(posedge clk or posedge rst_l) begin
    if (rst_l) begin
      count_r <= '0;
    end else if (flush) begin
      count_r <= '0;
    end else if (push_s && !pop_s) begin
      count_r <= count_r + CNTW'(1);
    end else if (pop_s && !push_s) begin
      count_r <= count_r - CNTW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  rvpipe_elastic_chk #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(CNTW)) u_chk (
    .clk       (clk),
    .rst_l     (rst_l),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count_r)
  );

endmodule
